// File: rtl/sram_ctrl.sv
// SRAM controller: copies a boot ROM image into on-chip RAM after reset,
// then maps CPU read/write strobes onto the single-port RAM.
module sram_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int INIT_WORDS = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [15:0]       ADDR,
    input  logic              OE,
    input  logic              WE,
    input  logic [15:0]       Data_to_SRAM,
    output logic [15:0]       Data_from_SRAM,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    output logic              init_done,
    output logic              oor_err
);

    typedef enum logic [1:0] {INIT_RD, INIT_WR, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(INIT_WORDS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_oor_q, rd_oor_d;
    logic [15:0]       dout_q, dout_d;
    logic              oor_q, oor_d;
    logic              in_range;

    assign in_range = (ADDR >> ADDR_W) == 16'd0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= INIT_RD;
            k_q       <= '0;
            rd_pend_q <= 1'b0;
            rd_oor_q  <= 1'b0;
            dout_q    <= 16'h0000;
            oor_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_pend_q <= rd_pend_d;
            rd_oor_q  <= rd_oor_d;
            dout_q    <= dout_d;
            oor_q     <= oor_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_pend_d = 1'b0;
        rd_oor_d  = 1'b0;
        dout_d    = dout_q;
        oor_d     = oor_q;
        ram_addr  = '0;
        ram_wren  = 1'b0;
        ram_wdata = 16'h0000;

        case (state_q)
            INIT_RD: begin
                state_d = INIT_WR;
            end
            INIT_WR: begin
                ram_addr  = k_q;
                ram_wdata = rom_data;
                ram_wren  = 1'b1;
                k_d       = k_q + 1'b1;
                state_d   = (k_q == LAST_WORD) ? RUN : INIT_RD;
            end
            RUN: begin
                if (!WE || !OE) begin
                    ram_addr = ADDR[ADDR_W-1:0];
                    if (!in_range) begin
                        oor_d = 1'b1;
                    end
                end
                // A write strobe always wins; the read path is only armed when WE is high.
                if (!WE) begin
                    if (in_range) begin
                        ram_wren  = 1'b1;
                        ram_wdata = Data_to_SRAM;
                    end
                end else if (!OE) begin
                    rd_pend_d = 1'b1;
                    rd_oor_d  = !in_range;
                end
                if (rd_pend_q) begin
                    dout_d = rd_oor_q ? 16'h0000 : ram_rdata;
                end
            end
            default: begin
                state_d = INIT_RD;
            end
        endcase
    end

    assign rom_addr       = k_q;
    assign Data_from_SRAM = dout_q;
    assign init_done      = (state_q == RUN);
    assign oor_err        = oor_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: boot copy, table-driven CPU accesses,
// randomized traffic against a memory model, and asynchronous reset cases.
module tb_sram_ctrl;

    localparam int AW = 10;
    localparam int NW = 4;
    localparam logic [15:0] ROM_W [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    logic          Clk = 1'b0;
    logic          Reset;
    logic [15:0]   ADDR;
    logic          OE;
    logic          WE;
    logic [15:0]   Data_to_SRAM;
    logic [15:0]   Data_from_SRAM;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic          init_done;
    logic          oor_err;

    int checks = 0;
    int errors = 0;

    sram_ctrl #(.ADDR_W(AW), .INIT_WORDS(NW)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .OE             (OE),
        .WE             (WE),
        .Data_to_SRAM   (Data_to_SRAM),
        .Data_from_SRAM (Data_from_SRAM),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .ram_addr       (ram_addr),
        .ram_wren       (ram_wren),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .init_done      (init_done),
        .oor_err        (oor_err)
    );

    always #5 Clk = ~Clk;

    // Synchronous ROM and RAM with one-cycle read latency.
    logic [15:0] ramMem [0:(1<<AW)-1];

    always @(posedge Clk) begin
        rom_data <= (rom_addr < AW'(NW)) ? ROM_W[rom_addr[1:0]] : 16'h0000;
    end

    always @(posedge Clk) begin
        if (ram_wren) begin
            ramMem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= ramMem[ram_addr];
    end

    // Reference model: expected RAM contents, read data and error flag.
    logic [15:0] refMem [0:(1<<AW)-1];
    logic [15:0] expDout;
    bit          expOor;
    bit          prevRd;
    logic [15:0] prevRdVal;
    bit          curRd, curWr, curAccess, curIn;
    logic [15:0] curAddr, curDin;

    typedef struct {
        logic        oe;
        logic        we;
        logic [15:0] addr;
        logic [15:0] din;
        logic        expWren;
        logic [9:0]  expRamAddr;
        logic [15:0] expWdata;
        logic [15:0] expDout;
        logic        expOor;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic oe, input logic we, input logic [15:0] addr,
                          input logic [15:0] din, input logic expWren,
                          input logic [9:0] expRamAddr, input logic [15:0] expWdata,
                          input logic [15:0] expDoutV, input logic expOorV);
        vec_t v;
        v.oe = oe; v.we = we; v.addr = addr; v.din = din;
        v.expWren = expWren; v.expRamAddr = expRamAddr; v.expWdata = expWdata;
        v.expDout = expDoutV; v.expOor = expOorV;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dout"},      Data_from_SRAM, 16'h0000);
        checkOutput({tag, "_init_done"}, init_done, 1'b0);
        checkOutput({tag, "_oor"},       oor_err, 1'b0);
        checkOutput({tag, "_wren"},      ram_wren, 1'b0);
        checkOutput({tag, "_ram_addr"},  ram_addr, 10'h000);
        checkOutput({tag, "_wdata"},     ram_wdata, 16'h0000);
        checkOutput({tag, "_rom_addr"},  rom_addr, 10'h000);
    endtask

    task automatic resetModel();
        expDout = 16'h0000;
        expOor = 1'b0;
        prevRd = 1'b0;
        curRd = 1'b0; curWr = 1'b0; curAccess = 1'b0; curIn = 1'b1;
    endtask

    // Drive one CPU cycle and compare mid-cycle against the model.
    task automatic applyStimulus(input logic oe, input logic we, input logic [15:0] addr,
                                 input logic [15:0] din);
        OE = oe; WE = we; ADDR = addr; Data_to_SRAM = din;
        curIn = (addr < 16'h0400);
        curWr = !we;
        curRd = !oe && we;
        curAccess = !oe || !we;
        curAddr = addr;
        curDin = din;
        @(negedge Clk);
        checkOutput("ram_wren", ram_wren, curWr && curIn);
        if (curWr && curIn) checkOutput("ram_wdata", ram_wdata, din);
        if (!curAccess) checkOutput("ram_addr_idle", ram_addr, 10'h000);
        else if (curIn) checkOutput("ram_addr", ram_addr, addr[9:0]);
        checkOutput("dout", Data_from_SRAM, expDout);
        checkOutput("oor_err", oor_err, expOor);
    endtask

    task automatic advance();
        @(posedge Clk);
        if (prevRd) expDout = prevRdVal;
        prevRd = curRd;
        prevRdVal = curIn ? refMem[curAddr[9:0]] : 16'h0000;
        if (curWr && curIn) refMem[curAddr[9:0]] = curDin;
        if (curAccess && !curIn) expOor = 1'b1;
        #1;
    endtask

    // Release reset and watch the copy; optionally drive CPU strobes to prove isolation.
    task automatic bootCheck(input bit isolate);
        int nw;
        nw = 0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        for (int i = 0; i < 2 * NW; i++) begin
            if (isolate) begin
                OE = (i < 4) ? 1'b1 : 1'b0;
                WE = (i < 4) ? 1'b0 : 1'b1;
                ADDR = (i < 4) ? 16'h0001 : 16'hFFFF;
                Data_to_SRAM = 16'hDEAD;
            end
            @(negedge Clk);
            checkOutput("boot_init_done_low", init_done, 1'b0);
            if (ram_wren) begin
                if (nw < NW) begin
                    checkOutput("boot_wr_addr", ram_addr, nw[9:0]);
                    checkOutput("boot_wr_data", ram_wdata, ROM_W[nw]);
                end
                nw++;
            end
            @(posedge Clk);
            #1;
        end
        OE = 1'b1; WE = 1'b1; ADDR = 16'h0000; Data_to_SRAM = 16'h0000;
        checkOutput("boot_wr_count", nw, NW);
        checkOutput("boot_init_done", init_done, 1'b1);
        checkOutput("boot_oor", oor_err, 1'b0);
        checkOutput("boot_dout", Data_from_SRAM, 16'h0000);
        resetModel();
        for (int i = 0; i < NW; i++) refMem[i] = ROM_W[i];
    endtask

    initial begin
        Reset = 1'b0;
        OE = 1'b1; WE = 1'b1; ADDR = 16'h0000; Data_to_SRAM = 16'h0000;
        for (int i = 0; i < (1 << AW); i++) begin
            ramMem[i] = 16'h0000;
            refMem[i] = 16'h0000;
        end
        resetModel();
        #2;
        checkResetValues("por");

        bootCheck(1'b1);

        //      oe    we    addr      din       wren  raddr    wdata     dout      oor
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h0000, 1'b0);
        addVec(1'b1, 1'b0, 16'h0010, 16'hBEEF, 1'b1, 10'h010, 16'hBEEF, 16'h0000, 1'b0);
        addVec(1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 10'h010, 16'h0000, 16'h0000, 1'b0);
        addVec(1'b1, 1'b1, 16'h0123, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h0000, 1'b0);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'hBEEF, 1'b0);
        addVec(1'b0, 1'b0, 16'h0005, 16'h1234, 1'b1, 10'h005, 16'h1234, 16'hBEEF, 1'b0);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'hBEEF, 1'b0);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'hBEEF, 1'b0);
        addVec(1'b0, 1'b1, 16'h0005, 16'h0000, 1'b0, 10'h005, 16'h0000, 16'hBEEF, 1'b0);
        addVec(1'b0, 1'b1, 16'h0001, 16'h0000, 1'b0, 10'h001, 16'h0000, 16'hBEEF, 1'b0);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h1234, 1'b0);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h2222, 1'b0);
        addVec(1'b1, 1'b0, 16'hFFFF, 16'h5555, 1'b0, 10'h000, 16'h0000, 16'h2222, 1'b0);
        addVec(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h2222, 1'b1);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h2222, 1'b1);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h0000, 1'b1);
        addVec(1'b1, 1'b0, 16'h03FF, 16'hA5A5, 1'b1, 10'h3FF, 16'hA5A5, 16'h0000, 1'b1);
        addVec(1'b0, 1'b1, 16'h03FF, 16'h0000, 1'b0, 10'h3FF, 16'h0000, 16'h0000, 1'b1);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h0000, 1'b1);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'hA5A5, 1'b1);
        addVec(1'b0, 1'b1, 16'h0400, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'hA5A5, 1'b1);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'hA5A5, 1'b1);
        addVec(1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 10'h000, 16'h0000, 16'h0000, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].oe, vecs[i].we, vecs[i].addr, vecs[i].din);
            checkOutput($sformatf("vec%0d_wren", i), ram_wren, vecs[i].expWren);
            if (vecs[i].expWren) checkOutput($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].expWdata);
            if (vecs[i].addr < 16'h0400) checkOutput($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].expRamAddr);
            checkOutput($sformatf("vec%0d_dout", i), Data_from_SRAM, vecs[i].expDout);
            checkOutput($sformatf("vec%0d_oor", i), oor_err, vecs[i].expOor);
            advance();
        end

        // Random traffic kept away from 0x0010 so its contents can be checked after reset.
        for (int i = 0; i < 300; i++) begin
            int op;
            logic [15:0] a;
            op = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(16'h0400, 16'hFFFF));
            else a = 16'h0100 + 16'($urandom_range(0, 31));
            applyStimulus((op == 2 || op == 3) ? 1'b0 : 1'b1,
                          (op == 1 || op == 3) ? 1'b0 : 1'b1,
                          a, 16'($urandom));
            advance();
        end

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0000);
        advance();
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000);
        advance();
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000);
        checkOutput("pre_reset_dout", Data_from_SRAM, 16'hBEEF);
        advance();

        Reset = 1'b0;
        #1;
        checkResetValues("rst_run");

        @(posedge Clk);
        #1;
        Reset = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        checkOutput("copy_word2_wren", ram_wren, 1'b1);
        checkOutput("copy_word2_addr", ram_addr, 10'h002);
        Reset = 1'b0;
        #1;
        checkResetValues("rst_copy");

        bootCheck(1'b0);

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h0000);
        advance();
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000);
        advance();
        applyStimulus(1'b1, 1'b1, 16'h0000, 16'h0000);
        checkOutput("ram_retained", Data_from_SRAM, 16'hBEEF);
        advance();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
